// File: rtl/frame_painter_if.sv
// Pixel write channel between the frame painter (master) and the graphic manager (slave).
interface frame_painter_if #(
    parameter int unsigned COLS = 320,
    parameter int unsigned ROWS = 240
);
    logic                    write_pixel;
    logic                    write_ready;
    logic                    bw_pixel_color;
    logic [$clog2(COLS)-1:0] pixel_col;
    logic [$clog2(ROWS)-1:0] pixel_row;

    modport master (
        output write_pixel,
        output bw_pixel_color,
        output pixel_col,
        output pixel_row,
        input  write_ready
    );

    modport slave (
        input  write_pixel,
        input  bw_pixel_color,
        input  pixel_col,
        input  pixel_row,
        output write_ready
    );
endinterface

// File: rtl/frame_painter.sv
// Copies a constant 1-bit frame from ROM into the graphic manager and paints a square brush at
// touch samples. Define PAINTER_ERASE_EN to add the `erase` input (brush paints black).
module frame_painter #(
    parameter int unsigned COLS     = 320,
    parameter int unsigned ROWS     = 240,
    parameter int unsigned N_FRAMES = 2,
    parameter int unsigned ADC_BITS = 12,
    parameter int unsigned BRUSH    = 3
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  en,
    input  logic [$clog2(N_FRAMES)-1:0]           load_frame_sel,
    output logic [$clog2(COLS*ROWS*N_FRAMES)-1:0] rom_addr,
    input  logic                                  rom_q,
    input  logic                                  initialized,
    frame_painter_if.master                       wr,
    input  logic                                  pos_ready,
    input  logic [ADC_BITS-1:0]                   x_pos,
    input  logic [ADC_BITS-1:0]                   y_pos,
`ifdef PAINTER_ERASE_EN
    input  logic                                  erase,
`endif
    output logic                                  busy
);

    localparam int unsigned SW     = $clog2(N_FRAMES);
    localparam int unsigned AW     = $clog2(COLS * ROWS * N_FRAMES);
    localparam int unsigned CW     = $clog2(COLS);
    localparam int unsigned RW     = $clog2(ROWS);
    localparam int unsigned PIX    = COLS * ROWS;
    localparam int unsigned IW     = $clog2(PIX);
    localparam int unsigned BW     = (BRUSH > 1) ? $clog2(BRUSH) : 1;
    localparam int unsigned XPW    = ADC_BITS + CW;
    localparam int unsigned YPW    = ADC_BITS + RW;
    localparam int          R      = int'((BRUSH - 1) / 2);
    localparam int          COLS_I = int'(COLS);
    localparam int          ROWS_I = int'(ROWS);

    localparam logic [2:0] StReset = 3'd0;
    localparam logic [2:0] StIdle  = 3'd1;
    localparam logic [2:0] StLdRd  = 3'd2;
    localparam logic [2:0] StLdWr  = 3'd3;
    localparam logic [2:0] StPaint = 3'd4;

    logic [2:0]    state_q, state_d;
    logic          pending_q, pending_d;
    logic [SW-1:0] frame_q, frame_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          held_q, held_d;
    logic          data_q, data_d;
    logic [CW-1:0] cx_q, cx_d;
    logic [RW-1:0] cy_q, cy_d;
    logic [BW-1:0] dx_q, dx_d;
    logic [BW-1:0] dy_q, dy_d;
    logic          busy_q;

    logic           sel_change;
    logic           load_active;
    logic           start_paint;
    logic           accept;
    logic           in_range;
    logic           brush_color;
    logic [XPW-1:0] x_prod;
    logic [YPW-1:0] y_prod;
    logic [CW-1:0]  cx_new;
    logic [RW-1:0]  cy_new;
    logic signed [31:0] tc;
    logic signed [31:0] tr;

    assign sel_change  = (state_q != StReset) && (load_frame_sel != frame_q);
    assign load_active = (state_q == StLdRd) || (state_q == StLdWr);
    assign start_paint = (state_q == StIdle) && pos_ready && en;
    assign accept      = wr.write_pixel && wr.write_ready;

    // Full-width products so the scaled centre never wraps before the shift.
    assign x_prod = XPW'(x_pos) * XPW'(COLS);
    assign y_prod = YPW'(y_pos) * YPW'(ROWS);
    assign cx_new = CW'(x_prod >> ADC_BITS);
    assign cy_new = RW'(y_prod >> ADC_BITS);

    assign tc       = $signed(32'(cx_q)) + $signed(32'(dx_q)) - R;
    assign tr       = $signed(32'(cy_q)) + $signed(32'(dy_q)) - R;
    assign in_range = (tc >= 0) && (tc < COLS_I) && (tr >= 0) && (tr < ROWS_I);

    assign rom_addr = AW'(frame_q) * AW'(PIX) + AW'(idx_q);
    assign busy     = busy_q;

`ifdef PAINTER_ERASE_EN
    logic erase_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            erase_q <= 1'b0;
        end else if (start_paint) begin
            erase_q <= erase;
        end
    end

    assign brush_color = ~erase_q;
`else
    assign brush_color = 1'b1;
`endif

    // Write channel is decoded from registered state, so it holds still while stalled.
    always_comb begin
        wr.write_pixel    = 1'b0;
        wr.bw_pixel_color = 1'b0;
        wr.pixel_col      = '0;
        wr.pixel_row      = '0;
        case (state_q)
            StLdWr: begin
                wr.write_pixel    = en && !sel_change;
                wr.bw_pixel_color = held_q ? data_q : rom_q;
                wr.pixel_col      = col_q;
                wr.pixel_row      = row_q;
            end
            StPaint: begin
                if (in_range) begin
                    wr.write_pixel    = 1'b1;
                    wr.bw_pixel_color = brush_color;
                    wr.pixel_col      = CW'(tc);
                    wr.pixel_row      = RW'(tr);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        frame_d   = frame_q;
        idx_d     = idx_q;
        col_d     = col_q;
        row_d     = row_q;
        held_d    = 1'b0;
        data_d    = data_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        dx_d      = dx_q;
        dy_d      = dy_q;

        case (state_q)
            StReset: begin
                if (initialized) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (start_paint) begin
                    state_d = StPaint;
                    cx_d    = cx_new;
                    cy_d    = cy_new;
                    dx_d    = '0;
                    dy_d    = '0;
                end else if (pending_q && en) begin
                    state_d = StLdRd;
                end
            end
            StLdRd: begin
                state_d = StLdWr;
            end
            StLdWr: begin
                if (!held_q) begin
                    data_d = rom_q;
                end
                if (accept) begin
                    if (idx_q == IW'(PIX - 1)) begin
                        pending_d = 1'b0;
                        state_d   = StIdle;
                        idx_d     = '0;
                        col_d     = '0;
                        row_d     = '0;
                    end else begin
                        state_d = StLdRd;
                        idx_d   = idx_q + 1'b1;
                        if (col_q == CW'(COLS - 1)) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end else begin
                    held_d = 1'b1;
                end
            end
            StPaint: begin
                // Off-screen offsets take one idle cycle; on-screen ones wait for acceptance.
                if (!in_range || accept) begin
                    if (dx_q == BW'(BRUSH - 1)) begin
                        dx_d = '0;
                        if (dy_q == BW'(BRUSH - 1)) begin
                            state_d = StIdle;
                        end else begin
                            dy_d = dy_q + 1'b1;
                        end
                    end else begin
                        dx_d = dx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StReset;
            end
        endcase

        if (load_active && (!en || sel_change)) begin
            state_d = en ? StLdRd : StIdle;
            idx_d   = '0;
            col_d   = '0;
            row_d   = '0;
            held_d  = 1'b0;
        end

        if (sel_change) begin
            frame_d   = load_frame_sel;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StReset;
            pending_q <= 1'b1;
            frame_q   <= '0;
            idx_q     <= '0;
            col_q     <= '0;
            row_q     <= '0;
            held_q    <= 1'b0;
            data_q    <= 1'b0;
            cx_q      <= '0;
            cy_q      <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            frame_q   <= frame_d;
            idx_q     <= idx_d;
            col_q     <= col_d;
            row_q     <= row_d;
            held_q    <= held_d;
            data_q    <= data_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            busy_q    <= (state_d != StIdle);
        end
    end

endmodule

// File: tb/tb_frame_painter.sv
// Directed bench: an 8x4 instance for frame loading and a 320x240 instance for brush painting.
module tb_frame_painter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   n_checks = 0;
    int   n_err    = 0;
    int   qs[$];
    int   qb[$];
    logic rom [0:63];

    // Small instance
    logic       en_s, sel_s, rom_q_s, init_s, busy_s;
    logic [5:0] rom_addr_s;
    frame_painter_if #(.COLS(8), .ROWS(4)) ifs ();

    // Large instance
    logic        en_b, sel_b, rom_q_b, pr_b, busy_b;
    logic [17:0] rom_addr_b;
    logic [11:0] x_b, y_b;
    frame_painter_if #(.COLS(320), .ROWS(240)) ifb ();
`ifdef PAINTER_ERASE_EN
    logic erase_b;
    localparam int ECOL = 0;
`else
    localparam int ECOL = 1;
`endif

    frame_painter #(.COLS(8), .ROWS(4), .N_FRAMES(2), .ADC_BITS(12), .BRUSH(3)) u_small (
        .clk            (clk),
        .reset          (reset),
        .en             (en_s),
        .load_frame_sel (sel_s),
        .rom_addr       (rom_addr_s),
        .rom_q          (rom_q_s),
        .initialized    (init_s),
        .wr             (ifs.master),
        .pos_ready      (1'b0),
        .x_pos          (12'd0),
        .y_pos          (12'd0),
`ifdef PAINTER_ERASE_EN
        .erase          (1'b0),
`endif
        .busy           (busy_s)
    );

    frame_painter #(.COLS(320), .ROWS(240), .N_FRAMES(2), .ADC_BITS(12), .BRUSH(3)) u_big (
        .clk            (clk),
        .reset          (reset),
        .en             (en_b),
        .load_frame_sel (sel_b),
        .rom_addr       (rom_addr_b),
        .rom_q          (rom_q_b),
        .initialized    (1'b1),
        .wr             (ifb.master),
        .pos_ready      (pr_b),
        .x_pos          (x_b),
        .y_pos          (y_b),
`ifdef PAINTER_ERASE_EN
        .erase          (erase_b),
`endif
        .busy           (busy_b)
    );

    function automatic int pk(input int c, input int r, input int k);
        return (c << 16) | (r << 4) | k;
    endfunction

    always @(posedge clk) rom_q_s <= rom[rom_addr_s];

    always @(negedge clk) begin
        if (!reset && ifs.write_pixel && ifs.write_ready)
            qs.push_back(pk(int'(ifs.pixel_col), int'(ifs.pixel_row), int'(ifs.bw_pixel_color)));
        if (!reset && ifb.write_pixel && ifb.write_ready)
            qb.push_back(pk(int'(ifb.pixel_col), int'(ifb.pixel_row), int'(ifb.bw_pixel_color)));
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_size(input int n, input int budget);
        int k = 0;
        while (qs.size() < n && k < budget) begin
            cyc(1);
            k++;
        end
    endtask

    task automatic wait_done(input bit big, input int n, input int budget, input string tag);
        int k = 0;
        do begin
            cyc(1);
            k++;
        end while ((((big ? qb.size() : qs.size()) < n) || (big ? busy_b : busy_s)) &&
                   k < budget);
        chk({tag, " count"}, big ? qb.size() : qs.size(), n);
        chk({tag, " idle"}, big ? busy_b : busy_s, 0);
    endtask

    task automatic check_frame(input int f, input string tag);
        for (int i = 0; i < qs.size() && i < 32; i++)
            chk($sformatf("%s px%0d", tag, i), qs[i], pk(i % 8, i / 8, int'(rom[f * 32 + i])));
    endtask

    initial begin
        int n;
        int exp_b [4];

        // f0 checkerboard, f1 set on every third pixel
        for (int i = 0; i < 32; i++) begin
            rom[i]      = 1'(((i % 8) + (i / 8)) % 2);
            rom[32 + i] = (i % 3 == 0);
        end
        reset = 1'b1;
        en_s = 1'b0; sel_s = 1'b0; init_s = 1'b0; ifs.write_ready = 1'b1;
        en_b = 1'b0; sel_b = 1'b0; rom_q_b = 1'b0; pr_b = 1'b0; x_b = '0; y_b = '0;
        ifb.write_ready = 1'b1;
`ifdef PAINTER_ERASE_EN
        erase_b = 1'b0;
`endif
        cyc(3);
        chk("rst write_pixel", ifs.write_pixel, 0);
        chk("rst busy", busy_s, 0);
        chk("rst rom_addr", rom_addr_s, 0);
        chk("rst col/row/color", pk(int'(ifs.pixel_col), int'(ifs.pixel_row),
                                     int'(ifs.bw_pixel_color)), 0);
        chk("rst busy big", busy_b, 0);

        // Waiting for the graphic manager: busy in RESET, nothing written
        reset = 1'b0;
        cyc(2);
        chk("uninit busy", busy_s, 1);
        chk("uninit write_pixel", ifs.write_pixel, 0);

        // 1: full load of frame 0
        init_s = 1'b1; en_s = 1'b1;
        wait_done(0, 32, 200, "t1");
        check_frame(0, "t1");
        cyc(4);
        chk("t1 no extra", qs.size(), 32);

        // 2: switch to frame 1, abort to frame 0 at idx 10, then back to frame 1 at idx 10
        qs.delete(); sel_s = 1'b1;
        wait_size(10, 100);
        chk("t2 partial f1", qs.size(), 10);
        qs.delete(); sel_s = 1'b0;
        wait_size(10, 100);
        chk("t2 restart f0", qs.size() > 0 ? qs[0] : -1, pk(0, 0, int'(rom[0])));
        qs.delete(); sel_s = 1'b1;
        cyc(1);
        chk("t2 rom_addr", rom_addr_s, 32);
        chk("t2 write dropped", ifs.write_pixel, 0);
        wait_done(0, 32, 200, "t2");
        check_frame(1, "t2");

        // 4: stall the write channel for five cycles mid-load
        qs.delete(); sel_s = 1'b0;
        n = 0;
        while (!(qs.size() >= 3 && ifs.write_pixel) && n < 50) begin
            cyc(1);
            n++;
        end
        n = qs.size();
        ifs.write_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk($sformatf("t4 hold valid %0d", i), ifs.write_pixel, 1);
            chk($sformatf("t4 hold data %0d", i),
                pk(int'(ifs.pixel_col), int'(ifs.pixel_row), int'(ifs.bw_pixel_color)),
                pk(n % 8, n / 8, int'(rom[n])));
        end
        ifs.write_ready = 1'b1;
        wait_done(0, 32, 200, "t4");
        check_frame(0, "t4");

        // 5: en drops at idx 5, reload restarts from pixel 0
        qs.delete(); sel_s = 1'b1;
        wait_size(5, 100);
        en_s = 1'b0;
        cyc(1);
        chk("t5 abort idle", busy_s, 0);
        chk("t5 abort no write", ifs.write_pixel, 0);
        cyc(8);
        chk("t5 no writes", qs.size(), 5);
        qs.delete(); en_s = 1'b1;
        wait_done(0, 32, 200, "t5");
        check_frame(1, "t5");

        // 3: brush at the right edge, centre (319,0)
        exp_b = '{pk(318, 0, 1), pk(319, 0, 1), pk(318, 1, 1), pk(319, 1, 1)};
        x_b = 12'd4095; y_b = 12'd0; en_b = 1'b1; pr_b = 1'b1;
        cyc(1);
        en_b = 1'b0; pr_b = 1'b0;
        chk("t3 busy", busy_b, 1);
        wait_done(1, 4, 40, "t3");
        for (int i = 0; i < qb.size() && i < 4; i++)
            chk($sformatf("t3 write %0d", i), qb[i], exp_b[i]);

        // 6: full brush around (160,120), eraser when built in
        qb.delete();
        x_b = 12'd2048; y_b = 12'd2048; en_b = 1'b1; pr_b = 1'b1;
`ifdef PAINTER_ERASE_EN
        erase_b = 1'b1;
`endif
        cyc(1);
        en_b = 1'b0; pr_b = 1'b0;
        wait_done(1, 9, 40, "t6");
        for (int i = 0; i < qb.size() && i < 9; i++)
            chk($sformatf("t6 write %0d", i), qb[i], pk(159 + i % 3, 119 + i / 3, ECOL));

        // pos_ready with en low is ignored
        qb.delete();
        pr_b = 1'b1;
        cyc(1);
        pr_b = 1'b0;
        chk("ign busy", busy_b, 0);
        cyc(12);
        chk("ign no writes", qb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
